// File: rtl/cypher_pkg.sv
// Shared types and constants for the cypher-lock digit sender.
package cypher_pkg;

  localparam int unsigned CYPHER_DIGITS = 4;
  localparam int unsigned DIGIT_W       = 4;
  localparam int unsigned CODE_W        = CYPHER_DIGITS * DIGIT_W;

  localparam logic [2:0] CTRL_IDLE = 3'd0;
  localparam logic [2:0] STEP_1    = 3'd1;
  localparam logic [2:0] STEP_2    = 3'd2;
  localparam logic [2:0] STEP_3    = 3'd3;
  localparam logic [2:0] STEP_4    = 3'd4;

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StStrobe,
    StWait,
    StDone,
    StFail
  } state_e;

  // Digit presented at a given step; step 1 is the low nibble.
  function automatic logic [DIGIT_W-1:0] digit_of(input logic [CODE_W-1:0] code,
                                                  input logic [2:0]        step);
    logic [DIGIT_W-1:0] d;
    d = '0;
    case (step)
      STEP_1:  d = code[0*DIGIT_W +: DIGIT_W];
      STEP_2:  d = code[1*DIGIT_W +: DIGIT_W];
      STEP_3:  d = code[2*DIGIT_W +: DIGIT_W];
      STEP_4:  d = code[3*DIGIT_W +: DIGIT_W];
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cypher_resp_timer.sv
// Response timer: counts WAIT cycles, flags the last permitted cycle.
module cypher_resp_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] Last = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] count_q;

  // Saturates at Last so a stalled enable can never wrap back to zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != Last)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired = (count_q == Last);

endmodule

// File: rtl/cypher_code_sender.sv
// Sends a latched 16-bit code to the cypher checker one nibble per step.
// Define CYPHER_RETRY_EN to restart from step 1 after a rejected digit; final_in is 'final'.
module cypher_code_sender
  import cypher_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [CODE_W-1:0]  code_in,
  input  logic               valid,
  input  logic               invalid,
  input  logic               final_in,
  input  logic               pespese,
  output logic [DIGIT_W-1:0] four_bit_out,
  output logic [2:0]         control_out,
  output logic               read,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic               timed_out
);

  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);

`ifdef CYPHER_RETRY_EN
  localparam bit RetryEn = 1'b1;
`else
  localparam bit RetryEn = 1'b0;
`endif

  state_e              state_q;
  logic [CODE_W-1:0]   code_q;
  logic [2:0]          step_q;
  logic [RetryW-1:0]   retry_q;
  logic                expired;
  logic                reject;

  assign reject = invalid | pespese;

  cypher_resp_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (state_q != StWait),
    .enable  (state_q == StWait),
    .expired (expired)
  );

  // Outputs are registered on entry to each state so they are valid for its whole cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      code_q       <= '0;
      step_q       <= CTRL_IDLE;
      retry_q      <= '0;
      four_bit_out <= '0;
      control_out  <= CTRL_IDLE;
      read         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fail         <= 1'b0;
      timed_out    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone, StFail: begin
          if (start) begin
            state_q      <= StDrive;
            code_q       <= code_in;
            step_q       <= STEP_1;
            retry_q      <= '0;
            control_out  <= STEP_1;
            four_bit_out <= digit_of(code_in, STEP_1);
            busy         <= 1'b1;
            done         <= 1'b0;
            fail         <= 1'b0;
            timed_out    <= 1'b0;
          end
        end
        StDrive: begin
          state_q <= StStrobe;
          read    <= 1'b1;
        end
        StStrobe: begin
          state_q <= StWait;
          read    <= 1'b0;
        end
        StWait: begin
          if (reject) begin
            if (RetryEn && (retry_q < RetryMax)) begin
              state_q      <= StDrive;
              step_q       <= STEP_1;
              retry_q      <= retry_q + 1'b1;
              control_out  <= STEP_1;
              four_bit_out <= digit_of(code_q, STEP_1);
            end else begin
              state_q      <= StFail;
              busy         <= 1'b0;
              fail         <= 1'b1;
              control_out  <= CTRL_IDLE;
              four_bit_out <= '0;
            end
          end else if (valid) begin
            if (step_q != STEP_4) begin
              state_q      <= StDrive;
              step_q       <= step_q + 3'd1;
              control_out  <= step_q + 3'd1;
              four_bit_out <= digit_of(code_q, step_q + 3'd1);
            end else if (final_in) begin
              state_q      <= StDone;
              busy         <= 1'b0;
              done         <= 1'b1;
              control_out  <= CTRL_IDLE;
              four_bit_out <= '0;
            end else begin
              state_q      <= StFail;
              busy         <= 1'b0;
              fail         <= 1'b1;
              control_out  <= CTRL_IDLE;
              four_bit_out <= '0;
            end
          end else if (expired) begin
            state_q      <= StFail;
            busy         <= 1'b0;
            fail         <= 1'b1;
            timed_out    <= 1'b1;
            control_out  <= CTRL_IDLE;
            four_bit_out <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
